// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: forwarding selects,
// the hard-wired zero register and the default mult/div latency.
package mips_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam int MULDIV_LAT_DEFAULT = 32;

   // A source only depends on a destination that is a real register; $0 never matches.
   function automatic logic regMatch(input logic [4:0] src, input logic [4:0] dst);
      return (dst != REG_ZERO) && (src == dst);
   endfunction

endpackage

// File: rtl/muldiv_busy_ctr.sv
// Tracks how many cycles remain until the mult/div unit's HI/LO results are valid.
module muldiv_busy_ctr
   import mips_pkg::*;
#(
   parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
   input  logic CLK,
   input  logic reset,
   input  logic MulDivStartE,
   output logic MulDivBusy
);

   localparam int PW = $clog2(MULDIV_LAT + 1);

   logic [PW-1:0] count_q;
   logic [PW-1:0] count_d;

   // A new start always reloads, even over an operation still in flight.
   always_comb begin
      count_d = count_q;
      if (MulDivStartE) begin
         count_d = PW'(MULDIV_LAT);
      end else if (count_q != '0) begin
         count_d = count_q - PW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign MulDivBusy = (count_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: forwarding selects, stall/flush for every
// pipeline register, mult/div sequencing and a saturating stall counter.
module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
   parameter int PERF_W     = 32
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [4:0]        RsD,
   input  logic [4:0]        RtD,
   input  logic [4:0]        RsE,
   input  logic [4:0]        RtE,
   input  logic [4:0]        WriteRegE,
   input  logic [4:0]        WriteRegM,
   input  logic [4:0]        WriteRegW,
   input  logic              RegWriteE,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              MemtoRegE,
   input  logic              MemtoRegM,
   input  logic              BranchD,
   input  logic              PCSrcD,
   input  logic              JumpD,
   input  logic              UsesHiLoD,
   input  logic              MulDivStartD,
   input  logic              MulDivStartE,
   input  logic              IMemReadyF,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic              ForwardAD,
   output logic              ForwardBD,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              MulDivBusy,
   output logic [PERF_W-1:0] StallCycles
);

   logic lwStall;
   logic branchStall;
   logic mdStall;
   logic dStall;

   logic [PERF_W-1:0] stallCycles_q;
   logic [PERF_W-1:0] stallCycles_d;

   muldiv_busy_ctr #(.MULDIV_LAT(MULDIV_LAT)) u_muldiv_busy_ctr (
      .CLK          (CLK),
      .reset        (reset),
      .MulDivStartE (MulDivStartE),
      .MulDivBusy   (MulDivBusy)
   );

   // Stall sources; overlapping sources collapse into one stall.
   always_comb begin
      lwStall     = MemtoRegE && (regMatch(RsD, RtE) || regMatch(RtD, RtE));
      branchStall = BranchD &&
                    ((RegWriteE && (regMatch(RsD, WriteRegE) || regMatch(RtD, WriteRegE))) ||
                     (MemtoRegM && (regMatch(RsD, WriteRegM) || regMatch(RtD, WriteRegM))));
      mdStall     = (MulDivBusy || MulDivStartE) && (UsesHiLoD || MulDivStartD);
      dStall      = lwStall || branchStall || mdStall;
   end

   // While reset is held the pipeline is drained: no stalls, both bubbles asserted.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (!reset) begin
         StallD    = dStall;
         StallF    = dStall || !IMemReadyF;
         FlushE    = dStall;
         FlushD    = !dStall && (PCSrcD || JumpD || !IMemReadyF);
         ForwardAD = RegWriteM && regMatch(RsD, WriteRegM);
         ForwardBD = RegWriteM && regMatch(RtD, WriteRegM);
         if (RegWriteM && regMatch(RsE, WriteRegM)) begin
            ForwardAE = FWD_MEM;
         end else if (RegWriteW && regMatch(RsE, WriteRegW)) begin
            ForwardAE = FWD_WB;
         end
         if (RegWriteM && regMatch(RtE, WriteRegM)) begin
            ForwardBE = FWD_MEM;
         end else if (RegWriteW && regMatch(RtE, WriteRegW)) begin
            ForwardBE = FWD_WB;
         end
      end
   end

   // Perf counter sticks at all-ones instead of wrapping.
   always_comb begin
      stallCycles_d = stallCycles_q;
      if (StallD && (stallCycles_q != '1)) begin
         stallCycles_d = stallCycles_q + PERF_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         stallCycles_q <= '0;
      end else begin
         stallCycles_q <= stallCycles_d;
      end
   end

   assign StallCycles = stallCycles_q;

endmodule
